// File: rtl/relu_stream_arbiter_pkg.sv
// Shared types for the packet-locked round-robin stream arbiter feeding the ReLU stage.
package relu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } beat_flags_t;

  // Channel-index width that stays at least 1 bit for tiny N.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/relu_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module rr_pick
  import relu_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    j     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum = {1'b0, ptr_i} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
      j = sum[CH_W-1:0];
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/relu_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one requantise/ReLU stage among N_CH streams.
// Optional mid-packet stall watchdog enabled by defining RELU_ARB_WDOG_EN.
module relu_stream_arbiter
  import relu_arb_pkg::*;
#(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned WDOG_CYCLES = 1024,
  localparam int unsigned CH_W        = ch_width(N_CH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH*DATA_WIDTH-1:0] data_i,
  input  logic [N_CH-1:0]            valid_i,
  input  logic [N_CH-1:0]            sop_i,
  input  logic [N_CH-1:0]            eop_i,
  input  logic [N_CH-1:0]            sof_i,
  input  logic [N_CH-1:0]            eof_i,
  output logic [N_CH-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       valid_o,
  output logic                       sop_o,
  output logic                       eop_o,
  output logic                       sof_o,
  output logic                       eof_o,
  output logic [CH_W-1:0]            ch_o,
  output logic                       busy_o,
  output logic                       proto_err_o,
  output logic                       timeout_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    beat_flags_t           f;
  } beat_t;

  function automatic logic [CH_W-1:0] inc_ch(input logic [CH_W-1:0] x);
    return (x == CH_W'(N_CH-1)) ? '0 : x + 1'b1;
  endfunction

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] owner_q, owner_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  beat_t           out_q, out_d;
  logic            valid_q, valid_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            perr_q, perr_d;
  logic [N_CH-1:0] ready;

  beat_t           in_beat [N_CH];
  logic [N_CH-1:0] pick_gnt;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;

`ifdef RELU_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;
`endif

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      in_beat[k].data  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      in_beat[k].f.sop = sop_i[k];
      in_beat[k].f.eop = eop_i[k];
      in_beat[k].f.sof = sof_i[k];
      in_beat[k].f.eof = eof_i[k];
    end
  end

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req_i (valid_i & sop_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    out_d   = '0;
    valid_d = 1'b0;
    ch_d    = '0;
    perr_d  = perr_q;
    ready   = '0;
`ifdef RELU_ARB_WDOG_EN
    wcnt_d  = '0;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready   = pick_gnt;
          valid_d = 1'b1;
          out_d   = in_beat[pick_idx];
          ch_d    = pick_idx;
          if (in_beat[pick_idx].f.eop) begin
            ptr_d = inc_ch(pick_idx);
          end else begin
            state_d = LOCK;
            owner_d = pick_idx;
          end
        end else begin
          // No sop anywhere: every pending beat is an orphan and gets drained.
          ready = valid_i;
          if (|valid_i) perr_d = 1'b1;
        end
      end
      LOCK: begin
        ready[owner_q] = 1'b1;
        if (valid_i[owner_q]) begin
          valid_d = 1'b1;
          out_d   = in_beat[owner_q];
          ch_d    = owner_q;
          if (in_beat[owner_q].f.sop) perr_d = 1'b1;
          if (in_beat[owner_q].f.eop) begin
            state_d = IDLE;
            ptr_d   = inc_ch(owner_q);
          end
`ifdef RELU_ARB_WDOG_EN
        end else if (wcnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          // This stall brings the count to WDOG_CYCLES: close the packet with a forced eop.
          valid_d     = 1'b1;
          out_d.f.eop = 1'b1;
          ch_d        = owner_q;
          tmo_d       = 1'b1;
          state_d     = IDLE;
          ptr_d       = inc_ch(owner_q);
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      perr_q  <= perr_d;
    end
  end

`ifdef RELU_ARB_WDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_d;
    end
  end
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Nothing is accepted while reset is held, even if the fabric presents beats.
  assign ready_o     = reset_n ? ready : '0;
  assign data_o      = out_q.data;
  assign valid_o     = valid_q;
  assign sop_o       = out_q.f.sop;
  assign eop_o       = out_q.f.eop;
  assign sof_o       = out_q.f.sof;
  assign eof_o       = out_q.f.eof;
  assign ch_o        = ch_q;
  assign busy_o      = (state_q == LOCK);
  assign proto_err_o = perr_q;

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Scoreboard bench for relu_stream_arbiter: per-stream beat buffers drive the inputs,
// expected output beats are queued by hand and popped by an independent monitor.
module tb_relu_stream_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*DW-1:0] data_i = '0;
  logic [N-1:0]    valid_i = '0, sop_i = '0, eop_i = '0, sof_i = '0, eof_i = '0;
  logic [N-1:0]    ready_o;
  logic [DW-1:0]   data_o;
  logic            valid_o, sop_o, eop_o, sof_o, eof_o;
  logic [1:0]      ch_o;
  logic            busy_o, proto_err_o, timeout_o;

  always #5 clk = ~clk;

  relu_stream_arbiter #(
    .N_CH        (N),
    .DATA_WIDTH  (DW),
    .WDOG_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sop_i       (sop_i),
    .eop_i       (eop_i),
    .sof_i       (sof_i),
    .eof_i       (eof_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .sop_o       (sop_o),
    .eop_o       (eop_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .ch_o        (ch_o),
    .busy_o      (busy_o),
    .proto_err_o (proto_err_o),
    .timeout_o   (timeout_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic sop, eop, sof, eof;
  } sbeat_t;

  typedef struct packed {
    logic [31:0] data;
    logic sop, eop, sof, eof;
    logic [1:0] ch;
    logic tmo;
  } obs_t;

  obs_t        exp_q[$];
  int          beat_cyc[$];
  sbeat_t      sbuf[N][32];
  int unsigned shead[N];
  int unsigned stail[N];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          busy_seen;
  bit          done;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat is matched against the head of the scoreboard.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && valid_o === 1'b1) begin
        a = {data_o, sop_o, eop_o, sof_o, eof_o, ch_o, timeout_o};
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", a);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic add_beat(input int ch, input logic [31:0] d, input logic sop, eop, sof, eof);
    sbuf[ch][stail[ch]] = {d, sop, eop, sof, eof};
    stail[ch]++;
  endtask

  task automatic expect_beat(input logic [1:0] ch, input logic [31:0] d,
                             input logic sop, eop, sof, eof, input logic tmo);
    exp_q.push_back({d, sop, eop, sof, eof, ch, tmo});
  endtask

  task automatic add_exp(input int ch, input logic [31:0] d, input logic sop, eop, sof, eof);
    add_beat(ch, d, sop, eop, sof, eof);
    expect_beat(2'(ch), d, sop, eop, sof, eof, 1'b0);
  endtask

  task automatic clear_inputs();
    valid_i = '0; sop_i = '0; eop_i = '0; sof_i = '0; eof_i = '0; data_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Presents each stream's head beat; a beat leaves its buffer only when valid&ready.
  task automatic run_engine(input int unsigned budget, output bit fin);
    logic [N-1:0] acc;
    sbeat_t b;
    fin = 1'b0;
    for (int unsigned c = 0; c < budget && !fin; c++) begin
      clear_inputs();
      for (int k = 0; k < N; k++) begin
        if (shead[k] != stail[k]) begin
          b = sbuf[k][shead[k]];
          valid_i[k] = 1'b1;
          data_i[k*DW +: DW] = b.data;
          sop_i[k] = b.sop; eop_i[k] = b.eop; sof_i[k] = b.sof; eof_i[k] = b.eof;
        end
      end
      #2;
      acc = valid_i & ready_o;
      if (busy_o) busy_seen = 1'b1;
      @(posedge clk); #1;
      fin = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) shead[k]++;
        if (shead[k] != stail[k]) fin = 1'b0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin shead[k] = 0; stail[k] = 0; end

    // 1. reset held with every stream presenting a sop&eop beat
    valid_i = '1; sop_i = '1; eop_i = '1; sof_i = '1; eof_i = '1; data_i = '1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", ready_o, 0);
      check("rst_outputs", {data_o, valid_o, sop_o, eop_o, sof_o, eof_o, ch_o, busy_o,
                            proto_err_o, timeout_o}, 0);
    end
    @(posedge clk); #1;
    clear_inputs();
    reset_n = 1'b1;
    idle(1);

    // 2. single stream, 4-beat line on stream 2
    busy_seen = 1'b0;
    add_exp(2, 32'h2000, 1, 0, 1, 0);
    add_exp(2, 32'h2001, 0, 0, 0, 0);
    add_exp(2, 32'h2002, 0, 0, 0, 0);
    add_exp(2, 32'h2003, 0, 1, 0, 1);
    run_engine(20, done);
    check("t2_done", done, 1);
    check("t2_busy_seen", busy_seen, 1);
    idle(2);
    check("t2_busy_fall", busy_o, 0);

    // 3. contention from streams 0,1,3 with pointer at 0
    pulse_reset();
    for (int k = 0; k < N; k++) begin
      if (k != 2) begin
        add_beat(k, 32'h0100 + 32'(k) * 32'h1000, 1, 0, 0, 0);
        add_beat(k, 32'h0101 + 32'(k) * 32'h1000, 0, 0, 0, 0);
        add_beat(k, 32'h0102 + 32'(k) * 32'h1000, 0, 1, 0, 0);
      end
    end
    expect_beat(0, 32'h0100, 1, 0, 0, 0, 0);
    expect_beat(0, 32'h0101, 0, 0, 0, 0, 0);
    expect_beat(0, 32'h0102, 0, 1, 0, 0, 0);
    expect_beat(1, 32'h1100, 1, 0, 0, 0, 0);
    expect_beat(1, 32'h1101, 0, 0, 0, 0, 0);
    expect_beat(1, 32'h1102, 0, 1, 0, 0, 0);
    expect_beat(3, 32'h3100, 1, 0, 0, 0, 0);
    expect_beat(3, 32'h3101, 0, 0, 0, 0, 0);
    expect_beat(3, 32'h3102, 0, 1, 0, 0, 0);
    run_engine(30, done);
    check("t3_done", done, 1);
    idle(1);

    // 4. single-beat lines on all streams; pointer expected back at 0
    for (int k = 0; k < N; k++) begin
      add_beat(k, 32'h4000 + 32'(k) * 32'h10, 1, 1, 1, 0);
      add_beat(k, 32'h4001 + 32'(k) * 32'h10, 1, 1, 0, 1);
    end
    expect_beat(0, 32'h4000, 1, 1, 1, 0, 0);
    expect_beat(1, 32'h4010, 1, 1, 1, 0, 0);
    expect_beat(2, 32'h4020, 1, 1, 1, 0, 0);
    expect_beat(3, 32'h4030, 1, 1, 1, 0, 0);
    expect_beat(0, 32'h4001, 1, 1, 0, 1, 0);
    expect_beat(1, 32'h4011, 1, 1, 0, 1, 0);
    expect_beat(2, 32'h4021, 1, 1, 0, 1, 0);
    expect_beat(3, 32'h4031, 1, 1, 0, 1, 0);
    run_engine(8, done);
    check("t4_done_8cyc", done, 1);
    idle(1);

    // 5. orphan beat on stream 1 while idle
    check("t5_perr_before", proto_err_o, 0);
    valid_i = 4'b0010;
    data_i[1*DW +: DW] = 32'h1234;
    #2;
    check("t5_orphan_ready", ready_o, 4'b0010);
    @(posedge clk); #1;
    clear_inputs();
    check("t5_valid_o", valid_o, 0);
    check("t5_perr_set", proto_err_o, 1);
    idle(1);

    // 6a. reset mid-packet returns to IDLE with pointer 0
    pulse_reset();
    check("t6_perr_cleared", proto_err_o, 0);
    add_exp(0, 32'h6000, 1, 1, 0, 0);
    run_engine(4, done);
    add_exp(2, 32'h6200, 1, 0, 0, 0);
    run_engine(4, done);
    check("t6_lock_done", done, 1);
    check("t6_busy_locked", busy_o, 1);
    @(negedge clk); #1;
    pulse_reset();
    check("t6_busy_after_rst", {busy_o, valid_o}, 0);
    add_exp(0, 32'h6001, 1, 1, 0, 0);
    add_exp(1, 32'h6101, 1, 1, 0, 0);
    run_engine(6, done);
    check("t6_after_rst_done", done, 1);
    idle(1);

    // 6b. owner (stream 2) stalls mid-packet while stream 3 waits
    add_exp(2, 32'h6300, 1, 0, 0, 0);
    add_beat(3, 32'h6333, 1, 1, 0, 0);
`ifdef RELU_ARB_WDOG_EN
    expect_beat(2, 32'h0, 0, 1, 0, 0, 1);
    expect_beat(3, 32'h6333, 1, 1, 0, 0, 0);
    run_engine(40, done);
    check("t6_wdog_done", done, 1);
    idle(2);
    check("t6_wdog_gap", beat_cyc[beat_cyc.size()-2] - beat_cyc[beat_cyc.size()-3], 8);
    check("t6_next_grant_gap", beat_cyc[beat_cyc.size()-1] - beat_cyc[beat_cyc.size()-2], 1);
`else
    run_engine(30, done);
    check("t6_lock_waits", done, 0);
    check("t6_still_busy", busy_o, 1);
    check("t6_no_timeout", timeout_o, 0);
    pulse_reset();
    for (int k = 0; k < N; k++) shead[k] = stail[k];
    idle(2);
`endif

    idle(3);
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
